range_session_ctrl: RTL and testbench
=====================================

Name: range_session_ctrl

Overview:
Sequencer for the RangeFinder datapath. It accepts a valid/ready sample stream and groups samples into measurement windows. For each window it drives RangeFinder's go/data/finish inputs, then captures the resulting range and error flag into a result record held on a valid/ready output. Sits between chip-level input pins or a sample source and the RangeFinder instance; RangeFinder shares this block's clock and reset.

Parameters:
WIDTH, 10, sample and range width (matches RangeFinder WIDTH).
WINDOW, 16, samples per window (>=1).
IDLE_TIMEOUT, 255, max consecutive stall cycles in RUN before a forced finish; 0 disables the timeout.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
sample_valid  input  1  sample_data is valid this cycle.
sample_ready  output  1  block accepts a sample this cycle.
sample_data  input  WIDTH  incoming sample.
flush  input  1  end the current window at the next accepted sample.
rf_data  output  WIDTH  to RangeFinder data_in.
rf_go  output  1  to RangeFinder go.
rf_finish  output  1  to RangeFinder finish.
rf_range  input  WIDTH  from RangeFinder range.
rf_error  input  1  from RangeFinder debug_error.
result_valid  output  1  result record valid.
result_ready  input  1  consumer accepts the result.
result_range  output  WIDTH  captured range (max-min of window).
result_count  output  $clog2(WINDOW+1)  samples accepted in the window.
result_error  output  1  rf_error captured at result time.
result_timeout  output  1  window ended by timeout.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async):
  - State=IDLE.
  - All result_* = 0; sample count = 0; stall counter = 0.
  - Held sample = 0; rf_go = rf_finish = 0.
- Accept = sample_valid && sample_ready.
- sample_ready = 1 in IDLE and RUN; 0 in WAIT_RES and HOLD.
- rf_data:
  - Equals sample_data on an accept.
  - Otherwise equals the held last-accepted sample.
  - Repeating a sample during gaps cannot change max-min.
- rf_go, rf_finish and rf_data are combinational from state, counters and the inputs.
- IDLE:
  - On accept: rf_go=1, count=1, hold sample.
  - If WINDOW==1 or flush: rf_finish=1 in the same cycle -> WAIT_RES.
  - Otherwise -> RUN.
  - flush without accept is ignored.
- RUN, on accept:
  - count+1, hold sample, stall counter cleared.
  - If the new count==WINDOW or flush: rf_finish=1 -> WAIT_RES.
- RUN, no accept:
  - Stall counter +1.
  - If IDLE_TIMEOUT!=0 and the stall counter reaches IDLE_TIMEOUT: rf_finish=1 with held data, timeout flag set -> WAIT_RES.
  - flush without accept does not end the window.
- WAIT_RES (exactly 1 cycle; RangeFinder range is valid the cycle after finish):
  - Capture rf_range, rf_error, count and timeout flag into result_*.
  - -> HOLD.
- HOLD:
  - result_valid=1; result_* stable while result_ready=0.
  - On result_ready: result_valid=0, count=0, timeout flag=0 -> IDLE.
  - The next window's first sample is accepted no earlier than the cycle after the handshake.
- Latency: last sample accepted at cycle T -> result_valid at T+2.
- Window total = 2 cycles + window length + consumer stall.
- Counter widths:
  - Sample count saturates at WINDOW by construction.
  - Stall counter is $clog2(IDLE_TIMEOUT+1) bits and never wraps.
- Reset mid-window: window discarded, no result, rf_finish never issued; RangeFinder is reset simultaneously.
- rf_go and rf_finish are never asserted outside IDLE/RUN.
- rf_go is asserted only once per window.

Decomposition:
- Shared package range_ctrl_pkg:
  - state enum {IDLE, RUN, WAIT_RES, HOLD}.
  - Default WIDTH constant.
  - result record struct (range, count, error, timeout).
- One natural sub-module: range_stall_timer (stall counter plus terminal flag, parameterised by IDLE_TIMEOUT, clear/inc inputs).
- The RangeFinder instance stays in the chip top-level, not inside this block.

Test Plan:
- WINDOW=4, back-to-back samples 5,12,3,9, result_ready=1 -> rf_go with 5; rf_finish with 9; result_range=9, count=4, error=0, timeout=0; result_valid two cycles after 9.
- Same samples with 3-cycle gaps between each -> rf_data holds the last value during gaps; identical result.
- flush with the second sample (7,20) -> rf_finish on 20; result_range=13, count=2.
- IDLE_TIMEOUT=8, one sample 42, then idle -> forced rf_finish 8 cycles later; range=0, count=1, timeout=1.
- result_ready=0 for 10 cycles in HOLD with sample_valid=1 -> sample_ready=0, result fields stable, no rf_go until after the handshake.
- Reset pulse mid-RUN after 2 samples -> all outputs 0 immediately; next window starts clean with rf_go on the next sample.

Source files
------------

// File: rtl/range_ctrl_pkg.sv
// Shared types for the RangeFinder session sequencer.
// Holds the FSM encoding, default width and result record layout.
package range_ctrl_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_RES = 2'd2,
        HOLD     = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] range;
        logic [DEF_CNT_W-1:0] count;
        logic                 error;
        logic                 timeout;
    } result_t;

endpackage

// File: rtl/range_stall_timer.sv
// Counts consecutive stall cycles inside a window.
// Flags the cycle whose increment reaches IDLE_TIMEOUT.
module range_stall_timer #(
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam int SW = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [SW-1:0] LIM = SW'(IDLE_TIMEOUT);
    localparam logic [SW-1:0] LAST = SW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    logic [SW-1:0] r_cnt;

    assign o_term = (IDLE_TIMEOUT != 0) && i_inc && (r_cnt == LAST);

    // Stall counter, saturating at the limit so it never wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/range_session_ctrl.sv
// Groups a valid/ready sample stream into RangeFinder windows
// and presents each window's range/error as a held result record.
module range_session_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int WINDOW       = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    input  logic [WIDTH-1:0]                 sample_data,
    input  logic                             flush,
    output logic [WIDTH-1:0]                 rf_data,
    output logic                             rf_go,
    output logic                             rf_finish,
    input  logic [WIDTH-1:0]                 rf_range,
    input  logic                             rf_error,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [WIDTH-1:0]                 result_range,
    output logic [$clog2(WINDOW+1)-1:0]      result_count,
    output logic                             result_error,
    output logic                             result_timeout,
    output logic                             busy
);

    localparam int CW = $clog2(WINDOW + 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_held;
    logic             r_timeout;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_range;
    logic [CW-1:0]    r_res_count;
    logic             r_res_error;
    logic             r_res_timeout;

    logic w_accept;
    logic w_run_last;
    logic w_term;
    logic w_clr;
    logic w_inc;

    assign sample_ready = (r_state == IDLE) || (r_state == RUN);
    assign w_accept     = sample_valid && sample_ready;
    assign w_run_last   = (r_count + CW'(1)) == CW'(WINDOW);
    assign rf_data      = w_accept ? sample_data : r_held;
    assign busy         = (r_state != IDLE);

    assign w_inc = (r_state == RUN) && !w_accept;
    assign w_clr = (r_state != RUN) || w_accept;

    assign result_valid   = r_res_valid;
    assign result_range   = r_res_range;
    assign result_count   = r_res_count;
    assign result_error   = r_res_error;
    assign result_timeout = r_res_timeout;

    range_stall_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_stall (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_term (w_term)
    );

    // RangeFinder strobes: go opens a window, finish closes it
    always_comb begin
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                rf_go     = w_accept;
                rf_finish = w_accept && ((WINDOW == 1) || flush);
            end
            RUN: begin
                if (w_accept) begin
                    rf_finish = w_run_last || flush;
                end else begin
                    rf_finish = w_term;
                end
            end
            default: begin
            end
        endcase
    end

    // Window sequencing, sample hold and result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_held        <= '0;
            r_timeout     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_range   <= '0;
            r_res_count   <= '0;
            r_res_error   <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count   <= CW'(1);
                        r_held    <= sample_data;
                        r_timeout <= 1'b0;
                        r_state   <= rf_finish ? WAIT_RES : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_count <= r_count + CW'(1);
                        r_held  <= sample_data;
                    end else if (w_term) begin
                        r_timeout <= 1'b1;
                    end
                    if (rf_finish) begin
                        r_state <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    r_res_valid   <= 1'b1;
                    r_res_range   <= rf_range;
                    r_res_count   <= r_count;
                    r_res_error   <= rf_error;
                    r_res_timeout <= r_timeout;
                    r_state       <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        r_res_valid <= 1'b0;
                        r_count     <= '0;
                        r_timeout   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_session_ctrl.sv
// Directed bench for range_session_ctrl with a behavioural
// RangeFinder stand-in (tracks min/max between go and finish).
module tb_range_session_ctrl;

    localparam int W  = 10;
    localparam int WN = 4;
    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] sample_data;
    logic         flush;
    logic [W-1:0] rf_data;
    logic         rf_go;
    logic         rf_finish;
    logic [W-1:0] rf_range;
    logic         rf_error;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result_range;
    logic [2:0]   result_count;
    logic         result_error;
    logic         result_timeout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    range_session_ctrl #(
        .WIDTH(W), .WINDOW(WN), .IDLE_TIMEOUT(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_data    (sample_data),
        .flush          (flush),
        .rf_data        (rf_data),
        .rf_go          (rf_go),
        .rf_finish      (rf_finish),
        .rf_range       (rf_range),
        .rf_error       (rf_error),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_range   (result_range),
        .result_count   (result_count),
        .result_error   (result_error),
        .result_timeout (result_timeout),
        .busy           (busy)
    );

    // RangeFinder stand-in: range valid the cycle after finish
    logic [W-1:0] m_mn, m_mx, n_mn, n_mx;
    assign n_mn = (rf_data < m_mn) ? rf_data : m_mn;
    assign n_mx = (rf_data > m_mx) ? rf_data : m_mx;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mn     <= '0;
            m_mx     <= '0;
            rf_range <= '0;
        end else if (rf_go) begin
            m_mn <= rf_data;
            m_mx <= rf_data;
            if (rf_finish) rf_range <= '0;
        end else begin
            m_mn <= n_mn;
            m_mx <= n_mx;
            if (rf_finish) rf_range <= n_mx - n_mn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold_check(input string tag, input int rng,
                              input int cnt, input int er, input int to);
        @(negedge clock);
        chk({tag, "_valid"}, 32'(result_valid), 1);
        chk({tag, "_range"}, 32'(result_range), rng);
        chk({tag, "_count"}, 32'(result_count), cnt);
        chk({tag, "_error"}, 32'(result_error), er);
        chk({tag, "_tmo"}, 32'(result_timeout), to);
    endtask

    int vals[4];
    int k;
    logic seen;

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        flush        = 1'b0;
        result_ready = 1'b1;
        rf_error     = 1'b0;
        vals         = '{5, 12, 3, 9};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rvalid", 32'(result_valid), 0);
        chk("rst_range", 32'(result_range), 0);
        chk("rst_count", 32'(result_count), 0);
        chk("rst_rdy", 32'(sample_ready), 1);
        chk("rst_data", 32'(rf_data), 0);
        reset = 1'b0;
        tick();

        // back-to-back window 5,12,3,9
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(vals[i]);
            @(negedge clock);
            chk("t1_go", 32'(rf_go), (i == 0) ? 1 : 0);
            chk("t1_fin", 32'(rf_finish), (i == 3) ? 1 : 0);
            chk("t1_data", 32'(rf_data), vals[i]);
            tick();
        end
        sample_valid = 1'b0;
        @(negedge clock);
        chk("t1_wait_rv", 32'(result_valid), 0);
        chk("t1_wait_rdy", 32'(sample_ready), 0);
        tick();
        hold_check("t1", 9, 4, 0, 0);
        tick();
        @(negedge clock);
        chk("t1_idle_rv", 32'(result_valid), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        tick();

        // same window with 3-cycle gaps
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(vals[i]);
            @(negedge clock);
            chk("t2_fin", 32'(rf_finish), (i == 3) ? 1 : 0);
            tick();
            sample_valid = 1'b0;
            sample_data  = W'(1000);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clock);
                    chk("t2_gap_data", 32'(rf_data), vals[i]);
                    chk("t2_gap_go", 32'(rf_go), 0);
                    tick();
                end
            end
        end
        tick();
        hold_check("t2", 9, 4, 0, 0);
        tick();

        // flush on the second sample
        sample_valid = 1'b1;
        sample_data  = W'(7);
        tick();
        sample_data = W'(20);
        flush       = 1'b1;
        @(negedge clock);
        chk("t3_fin", 32'(rf_finish), 1);
        tick();
        sample_valid = 1'b0;
        flush        = 1'b0;
        tick();
        hold_check("t3", 13, 2, 0, 0);
        tick();

        // timeout after one sample; flush alone must not end it
        rf_error     = 1'b1;
        sample_valid = 1'b1;
        sample_data  = W'(42);
        tick();
        sample_valid = 1'b0;
        sample_data  = W'(1);
        flush        = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            k++;
            @(negedge clock);
            if (rf_finish) begin
                seen = 1'b1;
                chk("t4_fin_data", 32'(rf_data), 42);
            end
            tick();
        end
        flush = 1'b0;
        chk("t4_fin_seen", 32'(seen), 1);
        chk("t4_fin_cycle", 32'(k), 8);
        tick();
        hold_check("t4", 0, 1, 1, 1);
        tick();
        rf_error = 1'b0;

        // consumer stall with samples pending
        result_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(i);
            tick();
        end
        sample_data = W'(99);
        tick();
        for (int c = 0; c < 10; c++) begin
            hold_check("t5", 3, 4, 0, 0);
            chk("t5_rdy", 32'(sample_ready), 0);
            chk("t5_go", 32'(rf_go), 0);
            tick();
        end
        result_ready = 1'b1;
        @(negedge clock);
        chk("t5_hs_rdy", 32'(sample_ready), 0);
        chk("t5_hs_go", 32'(rf_go), 0);
        tick();
        @(negedge clock);
        chk("t5_next_go", 32'(rf_go), 1);
        chk("t5_next_rv", 32'(result_valid), 0);
        tick();

        // reset mid-RUN after 2 samples (99, 60)
        sample_data = W'(60);
        tick();
        sample_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_go", 32'(rf_go), 0);
        chk("t6_fin", 32'(rf_finish), 0);
        chk("t6_rv", 32'(result_valid), 0);
        chk("t6_range", 32'(result_range), 0);
        chk("t6_count", 32'(result_count), 0);
        chk("t6_data", 32'(rf_data), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        vals = '{10, 30, 20, 15};
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = W'(vals[i]);
            @(negedge clock);
            chk("t6_go_n", 32'(rf_go), (i == 0) ? 1 : 0);
            chk("t6_fin_n", 32'(rf_finish), (i == 3) ? 1 : 0);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        hold_check("t6", 20, 4, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
